spi_reg_arbiter: RTL and testbench

- Shares one fixed-latency register bus between two requesters: the 4-wire SPI slave's event interface (address/write/read-sample events) and a local host port using a valid/ready handshake.
- Sits between the SPI slave and the register bank, in the user_clk domain.
- The SPI slave has no backpressure and needs read data one cycle after its sample event, so SPI always has absolute priority. Local requests are issued only in cycles with no SPI event.

---
 rtl/spi_reg_arb_pkg.sv | 21 ++
 rtl/spi_reg_arbiter.sv | 126 ++++++++++++
 tb/tb_spi_reg_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_arb_pkg.sv
// Shared types for the SPI/local register-bus arbiter: local FSM states,
// read-return owner tags and the address range check.
package spi_reg_arb_pkg;

  typedef enum logic [2:0] {
    L_IDLE  = 3'b001,
    L_ISSUE = 3'b010,
    L_RESP  = 3'b100
  } loc_state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SPI_RD = 2'd1,
    LOC    = 2'd2
  } owner_e;

  function automatic logic addr_is_oor(input logic [31:0] addr, input logic [31:0] max_addr);
    return addr > max_addr;
  endfunction

endpackage

// File: rtl/spi_reg_arbiter.sv
// Arbitrates a fixed-latency register bus between the SPI slave event port
// (absolute priority, zero latency) and a valid/ready local host port.
module spi_reg_arbiter
  import spi_reg_arb_pkg::*;
#(
  parameter int unsigned            AWIDTH    = 16,
  parameter int unsigned            DWIDTH    = 16,
  parameter logic [AWIDTH-1:0]      ADDR_MAX  = 16'h00FF,
  parameter logic [DWIDTH-1:0]      OOR_RDATA = 16'hDEAD
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic              spi_wr_evt,
  input  logic [DWIDTH-1:0] spi_wr_data,
  input  logic [AWIDTH-1:0] spi_addr,
  input  logic              spi_rd_samp_evt,
  output logic [DWIDTH-1:0] spi_rd_data,
  input  logic              loc_req_valid,
  output logic              loc_req_ready,
  input  logic              loc_req_we,
  input  logic [AWIDTH-1:0] loc_req_addr,
  input  logic [DWIDTH-1:0] loc_req_wdata,
  output logic              loc_rsp_valid,
  output logic [DWIDTH-1:0] loc_rsp_rdata,
  output logic              loc_rsp_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [AWIDTH-1:0] bus_addr,
  output logic [DWIDTH-1:0] bus_wdata,
  input  logic [DWIDTH-1:0] bus_rdata,
  output logic [7:0]        spi_oor_cnt
);

  loc_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              rd_oor_q;
  logic [DWIDTH-1:0] hold_q;

  logic              lat_we;
  logic [AWIDTH-1:0] lat_addr;
  logic [DWIDTH-1:0] lat_wdata;

  logic spi_evt, spi_oor, lat_oor, loc_issue;

  assign spi_evt = spi_wr_evt | spi_rd_samp_evt;
  assign spi_oor = addr_is_oor(32'(spi_addr), 32'(ADDR_MAX));
  assign lat_oor = addr_is_oor(32'(lat_addr), 32'(ADDR_MAX));

  always_comb begin
    state_d       = state_q;
    loc_req_ready = 1'b0;
    loc_issue     = 1'b0;
    unique case (state_q)
      L_IDLE: begin
        loc_req_ready = 1'b1;
        if (loc_req_valid) state_d = L_ISSUE;
      end
      L_ISSUE: begin
        if (!spi_evt) begin
          loc_issue = 1'b1;
          state_d   = L_RESP;
        end
      end
      L_RESP:  state_d = L_IDLE;
      default: state_d = L_IDLE;
    endcase
  end

  // SPI owns the bus whenever it has an event; a simultaneous write+read is
  // treated as a write and the read is dropped.
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    owner_d   = NONE;
    if (spi_evt) begin
      bus_req   = !spi_oor;
      bus_we    = spi_wr_evt;
      bus_addr  = spi_addr;
      bus_wdata = spi_wr_data;
      owner_d   = spi_wr_evt ? NONE : SPI_RD;
    end else if (loc_issue) begin
      bus_req   = !lat_oor;
      bus_we    = lat_we;
      bus_addr  = lat_addr;
      bus_wdata = lat_wdata;
      owner_d   = LOC;
    end
  end

  assign spi_rd_data = (owner_q == SPI_RD) ? (rd_oor_q ? OOR_RDATA : bus_rdata) : hold_q;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q       <= L_IDLE;
      owner_q       <= NONE;
      rd_oor_q      <= 1'b0;
      hold_q        <= '0;
      lat_we        <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      loc_rsp_valid <= 1'b0;
      loc_rsp_rdata <= '0;
      loc_rsp_err   <= 1'b0;
      spi_oor_cnt   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rd_oor_q <= spi_oor;
      if (owner_q == SPI_RD) hold_q <= spi_rd_data;
      if (loc_req_valid && loc_req_ready) begin
        lat_we    <= loc_req_we;
        lat_addr  <= loc_req_addr;
        lat_wdata <= loc_req_wdata;
      end
      if (spi_evt && spi_oor && (spi_oor_cnt != 8'hFF)) spi_oor_cnt <= spi_oor_cnt + 8'd1;
      loc_rsp_valid <= (state_q == L_RESP);
      if (state_q == L_RESP) begin
        loc_rsp_rdata <= lat_we ? '0 : (lat_oor ? OOR_RDATA : bus_rdata);
        loc_rsp_err   <= lat_oor;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Randomized self-checking bench for spi_reg_arbiter with a behavioural
// register-bank model and an array-based reference of expected contents.
module tb_spi_reg_arbiter;

  logic        user_clk, user_rst_n;
  logic        spi_wr_evt, spi_rd_samp_evt;
  logic [15:0] spi_wr_data, spi_addr, spi_rd_data;
  logic        loc_req_valid, loc_req_ready, loc_req_we;
  logic [15:0] loc_req_addr, loc_req_wdata, loc_rsp_rdata;
  logic        loc_rsp_valid, loc_rsp_err;
  logic        bus_req, bus_we;
  logic [15:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  spi_oor_cnt;

  int errors = 0;
  int checks = 0;

  logic [15:0] ref_mem [256];
  int          oor_exp = 0;
  logic [15:0] last_rd = '0;

  logic [15:0] mem [256];
  logic        pre_en;
  logic [7:0]  pre_a;
  logic [15:0] pre_d;

  spi_reg_arbiter #(
    .AWIDTH(16), .DWIDTH(16), .ADDR_MAX(16'h00FF), .OOR_RDATA(16'hDEAD)
  ) dut (
    .user_clk(user_clk), .user_rst_n(user_rst_n),
    .spi_wr_evt(spi_wr_evt), .spi_wr_data(spi_wr_data), .spi_addr(spi_addr),
    .spi_rd_samp_evt(spi_rd_samp_evt), .spi_rd_data(spi_rd_data),
    .loc_req_valid(loc_req_valid), .loc_req_ready(loc_req_ready), .loc_req_we(loc_req_we),
    .loc_req_addr(loc_req_addr), .loc_req_wdata(loc_req_wdata),
    .loc_rsp_valid(loc_rsp_valid), .loc_rsp_rdata(loc_rsp_rdata), .loc_rsp_err(loc_rsp_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .spi_oor_cnt(spi_oor_cnt)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  // Register bank: read data appears exactly one cycle after a read strobe,
  // random garbage otherwise so stale-data paths show up.
  always @(posedge user_clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (bus_req && bus_we) mem[bus_addr[7:0]] <= bus_wdata;
    if (bus_req && !bus_we) bus_rdata <= mem[bus_addr[7:0]];
    else bus_rdata <= 16'($urandom);
  end

  always @(posedge user_clk)
    assert (!(spi_wr_evt && spi_rd_samp_evt)) else $error("FAIL simultaneous SPI events driven");

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  function automatic bit oor(input logic [15:0] a);
    return a > 16'h00FF;
  endfunction

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge user_clk);
    pre_en = 1'b1; pre_a = a; pre_d = d;
    ref_mem[a] = d;
    @(negedge user_clk);
    pre_en = 1'b0;
  endtask

  task automatic spi_op(input bit wr, input logic [15:0] a, input logic [15:0] d);
    logic [15:0] exp_rd;
    @(negedge user_clk);
    spi_wr_evt = wr; spi_rd_samp_evt = !wr; spi_addr = a; spi_wr_data = d;
    #1;
    checks++;
    if (bus_req !== !oor(a)) begin
      errors++;
      $display("FAIL spi_bus_req addr=%h got=%b exp=%b", a, bus_req, !oor(a));
    end
    if (!oor(a)) begin
      checks++;
      if (bus_we !== wr || bus_addr !== a || (wr && bus_wdata !== d)) begin
        errors++;
        $display("FAIL spi_bus_fields we=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h",
                 bus_we, bus_addr, bus_wdata, wr, a, d);
      end
    end
    if (oor(a)) oor_exp = (oor_exp < 255) ? oor_exp + 1 : 255;
    else if (wr) ref_mem[a[7:0]] = d;
    exp_rd = oor(a) ? 16'hDEAD : ref_mem[a[7:0]];
    @(negedge user_clk);
    spi_wr_evt = 1'b0; spi_rd_samp_evt = 1'b0;
    #1;
    if (!wr) last_rd = exp_rd;
    checks++;
    if (spi_rd_data !== last_rd) begin
      errors++;
      $display("FAIL spi_rd_data addr=%h got=%h exp=%h", a, spi_rd_data, last_rd);
    end
    checks++;
    if (spi_oor_cnt !== 8'(oor_exp)) begin
      errors++;
      $display("FAIL spi_oor_cnt got=%0d exp=%0d", spi_oor_cnt, oor_exp);
    end
  endtask

  // k SPI writes stall the issue cycle; ovl places an SPI read in the response cycle.
  task automatic loc_txn(input bit we, input logic [15:0] a, input logic [15:0] d,
                         input int k, input bit ovl, input logic [15:0] ova);
    logic [15:0] exp_rdata, sa, sd;
    @(negedge user_clk);
    checks++;
    if (loc_req_ready !== 1'b1) begin
      errors++; $display("FAIL loc_ready_idle got=%b exp=1", loc_req_ready);
    end
    loc_req_valid = 1'b1; loc_req_we = we; loc_req_addr = a; loc_req_wdata = d;
    @(negedge user_clk);
    loc_req_valid = 1'b0; loc_req_we = 1'($urandom);
    loc_req_addr = 16'($urandom); loc_req_wdata = 16'($urandom);
    for (int i = 0; i < k; i++) begin
      sa = 16'($urandom_range(0, 255)); sd = 16'($urandom);
      spi_wr_evt = 1'b1; spi_addr = sa; spi_wr_data = sd;
      #1;
      checks++;
      if (bus_req !== 1'b1 || bus_addr !== sa || bus_wdata !== sd || loc_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL spi_priority req=%b addr=%h wdata=%h rdy=%b exp req=1 addr=%h wdata=%h rdy=0",
                 bus_req, bus_addr, bus_wdata, loc_req_ready, sa, sd);
      end
      ref_mem[sa[7:0]] = sd;
      @(negedge user_clk);
      spi_wr_evt = 1'b0;
    end
    #1;
    checks++;
    if (bus_req !== !oor(a) || (!oor(a) && (bus_we !== we || bus_addr !== a || (we && bus_wdata !== d)))) begin
      errors++;
      $display("FAIL loc_issue req=%b we=%b addr=%h wdata=%h exp req=%b we=%b addr=%h wdata=%h",
               bus_req, bus_we, bus_addr, bus_wdata, !oor(a), we, a, d);
    end
    if (!oor(a) && we) ref_mem[a[7:0]] = d;
    exp_rdata = we ? 16'h0000 : (oor(a) ? 16'hDEAD : ref_mem[a[7:0]]);
    @(negedge user_clk);
    if (ovl) begin
      spi_rd_samp_evt = 1'b1; spi_addr = ova;
    end
    #1;
    checks++;
    if (loc_rsp_valid !== 1'b0 || (ovl && (bus_req !== 1'b1 || bus_addr !== ova))) begin
      errors++;
      $display("FAIL loc_resp_cycle rsp_valid=%b bus_req=%b bus_addr=%h exp rsp_valid=0", loc_rsp_valid, bus_req, bus_addr);
    end
    @(negedge user_clk);
    spi_rd_samp_evt = 1'b0;
    #1;
    checks++;
    if (loc_rsp_valid !== 1'b1 || loc_rsp_rdata !== exp_rdata || loc_rsp_err !== oor(a)) begin
      errors++;
      $display("FAIL loc_rsp addr=%h we=%b stall=%0d valid=%b rdata=%h err=%b exp valid=1 rdata=%h err=%b",
               a, we, k, loc_rsp_valid, loc_rsp_rdata, loc_rsp_err, exp_rdata, oor(a));
    end
    if (ovl) last_rd = ref_mem[ova[7:0]];
    checks++;
    if (spi_rd_data !== last_rd) begin
      errors++; $display("FAIL overlap_spi_rd got=%h exp=%h", spi_rd_data, last_rd);
    end
    @(negedge user_clk);
    #1;
    checks++;
    if (loc_rsp_valid !== 1'b0 || loc_req_ready !== 1'b1 || spi_rd_data !== last_rd) begin
      errors++;
      $display("FAIL loc_after rsp_valid=%b ready=%b spi_rd=%h exp 0 1 %h",
               loc_rsp_valid, loc_req_ready, spi_rd_data, last_rd);
    end
  endtask

  task automatic test_reset;
    user_rst_n = 1'b0;
    repeat (3) @(negedge user_clk);
    #1;
    checks++;
    if (loc_req_ready !== 1'b1 || loc_rsp_valid !== 1'b0 || loc_rsp_rdata !== 16'h0 ||
        loc_rsp_err !== 1'b0 || spi_rd_data !== 16'h0 || spi_oor_cnt !== 8'h0 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_values ready=%b rv=%b rd=%h err=%b spi_rd=%h cnt=%h req=%b",
               loc_req_ready, loc_rsp_valid, loc_rsp_rdata, loc_rsp_err, spi_rd_data, spi_oor_cnt, bus_req);
    end
    @(negedge user_clk);
    user_rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge user_clk);
      pre_en = 1'b1; pre_a = 8'(i); pre_d = 16'($urandom);
      ref_mem[i] = pre_d;
    end
    @(negedge user_clk);
    pre_en = 1'b0;
  endtask

  task automatic test_spi_basic;
    spi_op(1'b1, 16'h0010, 16'h1234);
    preload(8'h20, 16'hBEEF);
    spi_op(1'b0, 16'h0020, 16'h0000);
    repeat (4) begin
      @(negedge user_clk);
      #1;
      checks++;
      if (spi_rd_data !== 16'hBEEF) begin
        errors++; $display("FAIL spi_rd_hold got=%h exp=BEEF", spi_rd_data);
      end
    end
  endtask

  task automatic test_local;
    preload(8'h05, 16'h00A5);
    loc_txn(1'b0, 16'h0005, 16'h0000, 0, 1'b0, 16'h0);
    loc_txn(1'b1, 16'h0040, 16'h5A5A, 1, 1'b0, 16'h0);
    loc_txn(1'b0, 16'h0040, 16'h0000, 2, 1'b1, 16'h0005);
  endtask

  task automatic test_oor;
    spi_op(1'b0, 16'h0100, 16'h0000);
    loc_txn(1'b1, 16'h0300, 16'h7777, 0, 1'b0, 16'h0);
    loc_txn(1'b0, 16'hFFFF, 16'h0000, 1, 1'b0, 16'h0);
    for (int i = 0; i < 258; i++) spi_op(1'b1, 16'h0100 + 16'(i), 16'($urandom));
  endtask

  task automatic test_random;
    int op;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 2);
      if (op == 0)      spi_op(1'b1, 16'($urandom_range(0, 511)), 16'($urandom));
      else if (op == 1) spi_op(1'b0, 16'($urandom_range(0, 511)), 16'h0000);
      else loc_txn(1'($urandom), 16'($urandom_range(0, 511)), 16'($urandom),
                   $urandom_range(0, 2), 1'($urandom), 16'($urandom_range(0, 255)));
    end
  endtask

  task automatic test_reset_mid_op;
    preload(8'h33, 16'hC0DE);
    spi_op(1'b0, 16'h0033, 16'h0000);
    @(negedge user_clk);
    loc_req_valid = 1'b1; loc_req_we = 1'b1; loc_req_addr = 16'h0044; loc_req_wdata = 16'h1111;
    @(negedge user_clk);
    loc_req_valid = 1'b0;
    #2 user_rst_n = 1'b0;
    #1;
    checks++;
    if (loc_req_ready !== 1'b1 || spi_rd_data !== 16'h0 || loc_rsp_valid !== 1'b0 || spi_oor_cnt !== 8'h0) begin
      errors++;
      $display("FAIL reset_mid_op ready=%b spi_rd=%h rv=%b cnt=%h exp 1 0000 0 00",
               loc_req_ready, spi_rd_data, loc_rsp_valid, spi_oor_cnt);
    end
    @(negedge user_clk);
    user_rst_n = 1'b1;
    last_rd = '0; oor_exp = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge user_clk);
      #1;
      checks++;
      if (loc_rsp_valid !== 1'b0 || bus_req !== 1'b0 || spi_rd_data !== 16'h0) begin
        errors++;
        $display("FAIL reset_no_rsp cyc=%0d rv=%b req=%b spi_rd=%h exp 0 0 0000", i, loc_rsp_valid, bus_req, spi_rd_data);
      end
    end
    loc_txn(1'b0, 16'h0044, 16'h0000, 0, 1'b0, 16'h0);
  endtask

  initial begin
    user_rst_n = 1'b0;
    spi_wr_evt = 1'b0; spi_rd_samp_evt = 1'b0; spi_addr = '0; spi_wr_data = '0;
    loc_req_valid = 1'b0; loc_req_we = 1'b0; loc_req_addr = '0; loc_req_wdata = '0;
    pre_en = 1'b0; pre_a = '0; pre_d = '0;
    test_reset();
    test_spi_basic();
    test_local();
    test_oor();
    test_random();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
